// File: rtl/if_else_delay_pipe.sv
// ---------------------------------------------------------------------------
// if_else_delay_pipe
//
// Purpose:
//   Parametrised if/else segment block. On every accepted start it evaluates
//   (input_bit == zero), optionally inverted, and chooses either then_data or
//   else_data. The chosen word travels through a DEPTH-stage pipeline with a
//   valid tag. When it reaches the end it appears on segment_0 together with a
//   one-cycle valid pulse. The block accepts one start per cycle. busy tells
//   the enclosing scheduler that accepted work has not yet produced valid.
//
// Parameters:
//   WIDTH    data width of all data ports
//   DEPTH    start-to-valid latency in cycles (1..64)
//   COND_INV 0: then_data when input_bit == zero; 1: then_data when !=
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   stall      in   freeze pipeline (only with IF_ELSE_DELAY_PIPE_STALL_EN)
//   start      in   launch; operands sampled on the same edge
//   input_bit  in   condition operand
//   zero       in   comparison operand
//   then_data  in   word selected when the condition holds
//   else_data  in   word selected otherwise
//   segment_0  out  last valid result (holds between results)
//   valid      out  one-cycle pulse per result
//   busy       out  high while accepted starts are still in flight
//
// Optional feature:
//   Defining IF_ELSE_DELAY_PIPE_STALL_EN adds the stall input. While stall=1
//   the whole pipeline, the counter and segment_0 freeze, valid is forced low
//   and start is ignored.
// ---------------------------------------------------------------------------
module if_else_delay_pipe #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1,
    parameter bit COND_INV = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef IF_ELSE_DELAY_PIPE_STALL_EN
    input  logic             stall,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] input_bit,
    input  logic [WIDTH-1:0] zero,
    input  logic [WIDTH-1:0] then_data,
    input  logic [WIDTH-1:0] else_data,
    output logic [WIDTH-1:0] segment_0,
    output logic             valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Debug-only control state; it follows the in-flight counter.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic logic f_cond(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        return (a == b) ^ COND_INV;
    endfunction

    function automatic logic [WIDTH-1:0] f_select(input logic             c,
                                                  input logic [WIDTH-1:0] t,
                                                  input logic [WIDTH-1:0] e);
        return c ? t : e;
    endfunction

    logic             w_stall;
    logic             w_start_acc;
    logic             w_cond;
    logic [WIDTH-1:0] w_sel;
    logic             w_tag_out;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_state_nxt;

    // Stage DEPTH-1 of r_data is the segment_0 register itself, so the new
    // result and the valid pulse appear in the same cycle.
    logic             r_tag  [0:DEPTH-1];
    logic [WIDTH-1:0] r_data [0:DEPTH-1];
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [1:0]       r_state;

`ifdef IF_ELSE_DELAY_PIPE_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_start_acc = start & ~w_stall;
    assign w_cond      = f_cond(input_bit, zero);
    assign w_sel       = f_select(w_cond, then_data, else_data);
    assign w_tag_out   = r_tag[DEPTH-1];

    // A result frozen at the output by stall is reported again once the
    // stall lifts, and it is retired from the counter only then.
    assign w_cnt_dec = w_tag_out & ~w_stall;

    // ---- stage 0 capture / stage i -> i+1 shift ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i]  <= 1'b0;
                r_data[i] <= '0;
            end
        end else if (!w_stall) begin
            r_tag[0] <= w_start_acc;
            if (w_start_acc) begin
                r_data[0] <= w_sel;
            end
            for (int i = 1; i < DEPTH; i++) begin
                r_tag[i] <= r_tag[i-1];
                // Inner stages shift freely; the output stage holds its
                // word until a tagged result arrives.
                if ((i != DEPTH - 1) || r_tag[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_start_acc && !w_cnt_dec) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (!w_start_acc && w_cnt_dec) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (w_cnt_nxt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_start_acc) begin
                    w_state_nxt = ST_RUN;
                end else if (!w_stall) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---- in-flight counter / busy / control state ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_cnt_nxt != '0);
            r_state <= w_state_nxt;
        end
    end

    assign segment_0 = r_data[DEPTH-1];
    assign valid     = w_tag_out & ~w_stall;
    assign busy      = r_busy;

endmodule

// File: tb/tb_if_else_delay_pipe.sv
module tb_if_else_delay_pipe;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s1, s4, s8;
    logic [31:0] ib, zr, th, el;
    logic [31:0] seg1, seg4, seg8;
    logic        v1, v4, v8, b1, b4, b8;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int peak   = 0;

    exp_t q1[$];
    exp_t q4[$];
    exp_t q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    if_else_delay_pipe #(.WIDTH(32), .DEPTH(1), .COND_INV(1'b0)) u_d1 (
        .clk(clk), .reset(rst_n),
`ifdef IF_ELSE_DELAY_PIPE_STALL_EN
        .stall(1'b0),
`endif
        .start(s1), .input_bit(ib), .zero(zr), .then_data(th), .else_data(el),
        .segment_0(seg1), .valid(v1), .busy(b1));

    if_else_delay_pipe #(.WIDTH(32), .DEPTH(4), .COND_INV(1'b0)) u_d4 (
        .clk(clk), .reset(rst_n),
`ifdef IF_ELSE_DELAY_PIPE_STALL_EN
        .stall(1'b0),
`endif
        .start(s4), .input_bit(ib), .zero(zr), .then_data(th), .else_data(el),
        .segment_0(seg4), .valid(v4), .busy(b4));

    if_else_delay_pipe #(.WIDTH(32), .DEPTH(8), .COND_INV(1'b1)) u_d8 (
        .clk(clk), .reset(rst_n),
`ifdef IF_ELSE_DELAY_PIPE_STALL_EN
        .stall(1'b0),
`endif
        .start(s8), .input_bit(ib), .zero(zr), .then_data(th), .else_data(el),
        .segment_0(seg8), .valid(v8), .busy(b8));

`ifdef IF_ELSE_DELAY_PIPE_STALL_EN
    logic        s3, stall3, v3, b3;
    logic [31:0] seg3;
    exp_t        q3[$];

    if_else_delay_pipe #(.WIDTH(32), .DEPTH(3), .COND_INV(1'b0)) u_d3 (
        .clk(clk), .reset(rst_n), .stall(stall3),
        .start(s3), .input_bit(ib), .zero(zr), .then_data(th), .else_data(el),
        .segment_0(seg3), .valid(v3), .busy(b3));
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] t, input logic [31:0] e,
                                          input bit inv);
        return (((a == b) ? 1'b1 : 1'b0) != inv) ? t : e;
    endfunction

    // Scoreboard monitors: pop one expectation per valid and check word and cycle.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && v1) begin
            if (q1.size() == 0) check("d1_spurious_valid", {31'd0, v1}, 32'd0);
            else begin
                e = q1.pop_front();
                check("d1_data", seg1, e.data);
                check("d1_latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst_n && v4) begin
            if (q4.size() == 0) check("d4_spurious_valid", {31'd0, v4}, 32'd0);
            else begin
                e = q4.pop_front();
                check("d4_data", seg4, e.data);
                check("d4_latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n && v8) begin
            if (q8.size() == 0) check("d8_spurious_valid", {31'd0, v8}, 32'd0);
            else begin
                e = q8.pop_front();
                check("d8_data", seg8, e.data);
                check("d8_latency", cyc, e.due);
            end
        end
    end

`ifdef IF_ELSE_DELAY_PIPE_STALL_EN
    always @(negedge clk) begin : mon3
        exp_t e;
        if (rst_n && v3) begin
            if (q3.size() == 0) check("d3_spurious_valid", {31'd0, v3}, 32'd0);
            else begin
                e = q3.pop_front();
                check("d3_data", seg3, e.data);
                check("d3_latency", cyc, e.due);
            end
        end
    end
`endif

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n = 1'b0;
        s1 = 1'b0; s4 = 1'b0; s8 = 1'b0;
        ib = '0; zr = '0; th = '0; el = '0;
`ifdef IF_ELSE_DELAY_PIPE_STALL_EN
        s3 = 1'b0; stall3 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_d1", {31'd0, v1}, 32'd0);
        check("rst_seg_d1", seg1, 32'd0);
        check("rst_busy_d1", {31'd0, b1}, 32'd0);
        check("rst_valid_d4", {31'd0, v4}, 32'd0);
        check("rst_seg_d4", seg4, 32'd0);
        check("rst_busy_d4", {31'd0, b4}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // DEPTH=1: condition true selects then_data, one-cycle latency.
        ib = 32'd0; zr = 32'd0; th = 32'hAAAA0001; el = 32'h5555;
        s1 = 1'b1;
        q1.push_back('{model(ib, zr, th, el, 1'b0), cyc + 1});
        @(posedge clk); #1;
        s1 = 1'b0;
        check("d1_valid_next", {31'd0, v1}, 32'd1);
        check("d1_seg_next", seg1, 32'hAAAA0001);
        check("d1_busy_on", {31'd0, b1}, 32'd1);
        @(posedge clk); #1;
        check("d1_busy_off", {31'd0, b1}, 32'd0);
        check("d1_valid_off", {31'd0, v1}, 32'd0);
        check("d1_seg_hold", seg1, 32'hAAAA0001);

        // DEPTH=4: condition false selects else_data after four cycles.
        ib = 32'd7; zr = 32'd0; th = 32'hDEAD; el = 32'h1234;
        s4 = 1'b1;
        q4.push_back('{model(ib, zr, th, el, 1'b0), cyc + 4});
        @(posedge clk); #1;
        s4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("d4_busy_window", {31'd0, b4}, 32'd1);
            check("d4_valid_timing", {31'd0, v4}, (i == 3) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        check("d4_busy_drop", {31'd0, b4}, 32'd0);
        check("d4_seg_after", seg4, 32'h1234);
        @(posedge clk); #1;
        check("d4_seg_hold", seg4, 32'h1234);

        // DEPTH=4: five back-to-back starts, all conditions true.
        ib = 32'd3; zr = 32'd3; el = 32'hFFFF;
        peak = 0;
        for (int j = 1; j <= 5; j++) begin
            th = j;
            s4 = 1'b1;
            q4.push_back('{model(ib, zr, th, el, 1'b0), cyc + 4});
            @(posedge clk); #1;
            if (int'(u_d4.r_cnt) > peak) peak = int'(u_d4.r_cnt);
        end
        s4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("d4_burst_busy", {31'd0, b4}, 32'd1);
            @(posedge clk); #1;
            if (int'(u_d4.r_cnt) > peak) peak = int'(u_d4.r_cnt);
        end
        check("d4_burst_busy_drop", {31'd0, b4}, 32'd0);
        check("d4_burst_seg_last", seg4, 32'd5);
        check("d4_counter_peak", peak, 32'd4);

        // COND_INV=1, DEPTH=8: equal operands select else_data; unequal select then_data.
        ib = 32'h10; zr = 32'h10; th = 32'h1111; el = 32'h2222;
        s8 = 1'b1;
        q8.push_back('{model(ib, zr, th, el, 1'b1), cyc + 8});
        @(posedge clk); #1;
        ib = 32'h11; th = 32'h3333; el = 32'h4444;
        q8.push_back('{model(ib, zr, th, el, 1'b1), cyc + 8});
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("d8_seg_then", seg8, 32'h3333);
        check("d8_busy_idle", {31'd0, b8}, 32'd0);

        // Reset with two results in flight at DEPTH=8.
        ib = 32'h5; zr = 32'h6; th = 32'h5151; el = 32'h6161;
        s8 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("d8_rst_valid", {31'd0, v8}, 32'd0);
        check("d8_rst_seg", seg8, 32'd0);
        check("d8_rst_busy", {31'd0, b8}, 32'd0);
        q8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("d8_no_valid_after_rst", {31'd0, v8}, 32'd0);
        end

`ifdef IF_ELSE_DELAY_PIPE_STALL_EN
        // DEPTH=3 with a five-cycle stall right after the start.
        ib = 32'd1; zr = 32'd1; th = 32'd9; el = 32'd0;
        s3 = 1'b1;
        q3.push_back('{model(ib, zr, th, el, 1'b0), cyc + 3 + 5});
        @(posedge clk); #1;
        s3 = 1'b0;
        stall3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("d3_valid_in_stall", {31'd0, v3}, 32'd0);
            if (i == 1) begin
                s3 = 1'b1;
                th = 32'h77;
            end else begin
                s3 = 1'b0;
            end
            @(posedge clk); #1;
        end
        stall3 = 1'b0;
        s3 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("d3_seg_after_stall", seg3, 32'd9);
        check("d3_busy_idle", {31'd0, b3}, 32'd0);
        check("d3_queue_empty", q3.size(), 32'd0);
`endif

        repeat (12) @(posedge clk);
        #1;
        check("d1_queue_empty", q1.size(), 32'd0);
        check("d4_queue_empty", q4.size(), 32'd0);
        check("d8_queue_empty", q8.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
